// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg
// Shared definitions for the serial ADC capture path: FSM state encoding,
// default timing parameters and the drop counter width.
package adc_capture_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVERT = 3'd1,
        SHIFT   = 3'd2,
        LATCH   = 3'd3,
        WAIT    = 3'd4
    } cap_state_e;

    localparam int DEF_DATA_WIDTH    = 14;
    localparam int DEF_CONV_CYCLES   = 40;
    localparam int DEF_SCLK_HALF     = 2;
    localparam int DEF_SAMPLE_PERIOD = 200;
    localparam int DROP_COUNT_WIDTH  = 8;

endpackage

// File: rtl/sample_period_timer.sv
// sample_period_timer
// Loadable down-counter with an at-zero flag. Counts down by one every clk
// cycle and parks at zero; load takes priority over counting.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   load         load load_val this cycle
//   load_val     value to load (count reaches zero load_val cycles later)
//   zero         counter is at zero
module sample_period_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/adc_serial_capture_ctrl.sv
// adc_serial_capture_ctrl
// Runs the ADC conversion cadence (CNV pulse, serial clock), strobes the
// external deserialising shift register, and hands each completed word
// downstream on a valid/ready handshake with overrun/drop accounting.
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   start_en       free-run enable, sampled in IDLE and at the end of WAIT
//   adc_cnv        conversion start to ADC
//   adc_sclk       serial clock to ADC
//   sr_enable      one-cycle shift strobe to the shift register
//   sr_q           parallel shift-register output
//   sample_data    captured word (MSB = first bit shifted)
//   sample_valid   sample_data holds an untransferred word
//   sample_ready   downstream accepts word
//   overrun        one-cycle pulse when a word is dropped
//   drop_count     saturating count of dropped words
module adc_serial_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int CONV_CYCLES   = DEF_CONV_CYCLES,
    parameter int SCLK_HALF     = DEF_SCLK_HALF,
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start_en,
    output logic                        adc_cnv,
    output logic                        adc_sclk,
    output logic                        sr_enable,
    input  logic [DATA_WIDTH-1:0]       sr_q,
    output logic [DATA_WIDTH-1:0]       sample_data,
    output logic                        sample_valid,
    input  logic                        sample_ready,
    output logic                        overrun,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

    // SAMPLE_PERIOD bounds every countdown, so one width serves both timers.
    localparam int TIMER_W = $clog2(SAMPLE_PERIOD);
    localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    cap_state_e         state, state_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_nxt;
    logic               sclk_nxt, sren_nxt;
    logic               per_load, per_zero;
    logic               ph_load, ph_zero;
    logic [TIMER_W-1:0] ph_val;
    logic               latch;

    always_ff @(posedge clk) begin
        assert (SAMPLE_PERIOD >= CONV_CYCLES + 2 * SCLK_HALF * DATA_WIDTH + 2)
            else $error("adc_serial_capture_ctrl: SAMPLE_PERIOD too short for one capture");
    end

    // Period timer: loaded on every CNV rise, so rises are SAMPLE_PERIOD apart.
    sample_period_timer #(.WIDTH(TIMER_W)) u_period (
        .clk      (clk),
        .resetn   (resetn),
        .load     (per_load),
        .load_val (TIMER_W'(SAMPLE_PERIOD - 1)),
        .zero     (per_zero)
    );

    // Phase timer: CONVERT length and each sclk half-phase.
    sample_period_timer #(.WIDTH(TIMER_W)) u_phase (
        .clk      (clk),
        .resetn   (resetn),
        .load     (ph_load),
        .load_val (ph_val),
        .zero     (ph_zero)
    );

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        sclk_nxt  = adc_sclk;
        sren_nxt  = 1'b0;
        per_load  = 1'b0;
        ph_load   = 1'b0;
        ph_val    = '0;
        case (state)
            IDLE: begin
                if (start_en) begin
                    state_nxt = CONVERT;
                    per_load  = 1'b1;
                    ph_load   = 1'b1;
                    ph_val    = TIMER_W'(CONV_CYCLES - 1);
                end
            end
            CONVERT: begin
                if (ph_zero) begin
                    state_nxt = SHIFT;
                    bit_nxt   = '0;
                    ph_load   = 1'b1;
                    ph_val    = TIMER_W'(SCLK_HALF - 1);
                end
            end
            SHIFT: begin
                if (ph_zero) begin
                    if (!adc_sclk) begin
                        // low phase done: rise sclk and strobe the shift register once
                        sclk_nxt = 1'b1;
                        sren_nxt = 1'b1;
                        ph_load  = 1'b1;
                        ph_val   = TIMER_W'(SCLK_HALF - 1);
                    end else if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                        sclk_nxt  = 1'b0;
                        state_nxt = LATCH;
                    end else begin
                        sclk_nxt = 1'b0;
                        bit_nxt  = bit_cnt + 1'b1;
                        ph_load  = 1'b1;
                        ph_val   = TIMER_W'(SCLK_HALF - 1);
                    end
                end
            end
            LATCH: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (per_zero) begin
                    if (start_en) begin
                        state_nxt = CONVERT;
                        per_load  = 1'b1;
                        ph_load   = 1'b1;
                        ph_val    = TIMER_W'(CONV_CYCLES - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                sclk_nxt  = 1'b0;
            end
        endcase
    end

    // Pin outputs are registered from next-state values so they line up
    // with the state they belong to.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            adc_cnv   <= 1'b0;
            adc_sclk  <= 1'b0;
            sr_enable <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_nxt;
            adc_cnv   <= (state_nxt == CONVERT);
            adc_sclk  <= sclk_nxt;
            sr_enable <= sren_nxt;
        end
    end

    assign latch = (state == LATCH);

    // Holding register: a transfer in the LATCH cycle frees the slot for
    // the new word, so valid stays high without a drop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            drop_count   <= '0;
        end else begin
            overrun <= 1'b0;
            if (latch) begin
                if (!sample_valid || sample_ready) begin
                    sample_data  <= sr_q;
                    sample_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                    if (drop_count != '1) begin
                        drop_count <= drop_count + 1'b1;
                    end
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_serial_capture_ctrl.sv
// tb_adc_serial_capture_ctrl
// Directed bench: ADC + shift-register model, cycle-indexed checks relative
// to the first adc_cnv cycle of each run (cyc = 0).
module tb_adc_serial_capture_ctrl;

    localparam int DW = 14;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start_en = 1'b0;
    logic          sample_ready = 1'b0;
    logic          adc_cnv, adc_sclk, sr_enable, sample_valid, overrun;
    logic [DW-1:0] sr_q = '0;
    logic [DW-1:0] sample_data;
    logic [7:0]    drop_count;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [DW-1:0] adc_word = '0;
    int            adc_idx  = 0;
    logic          sdo      = 1'b0;

    always #5 clk = ~clk;

    adc_serial_capture_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .start_en     (start_en),
        .adc_cnv      (adc_cnv),
        .adc_sclk     (adc_sclk),
        .sr_enable    (sr_enable),
        .sr_q         (sr_q),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .drop_count   (drop_count)
    );

    // ADC: presents the next bit, MSB first, on each sclk rise.
    always @(posedge adc_cnv) adc_idx = 0;
    always @(posedge adc_sclk) begin
        if (adc_idx < DW) sdo = adc_word[DW-1-adc_idx];
        adc_idx++;
    end

    // Downstream shift register in shift mode, d[0] = sdo.
    always @(posedge clk) if (sr_enable) sr_q <= {sr_q[DW-2:0], sdo};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic adv_to(input int t);
        while (cyc < t) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Caller sits at a negedge with the FSM in IDLE.
    task automatic go(input string tag);
        start_en = 1'b1;
        @(negedge clk);
        cyc = 0;
        chk({tag, "_cnv0"}, adc_cnv, 1);
    endtask

    // Full-conversion waveform and delivery check, sample_ready held 1.
    task automatic chk_conv(input string tag, input logic [DW-1:0] w);
        int cnv_bad = 0, sclk_bad = 0, sren_bad = 0, sren_cnt = 0, ovr_cnt = 0;
        logic v96 = 1'b0, v97 = 1'b0, v98 = 1'b0;
        logic [DW-1:0] d97 = '0;
        logic e_cnv, e_sclk, e_sren;
        adc_word = w;
        while (cyc <= 98) begin
            e_cnv  = (cyc < 40);
            e_sclk = (cyc >= 40) && (cyc < 96) && (((cyc - 40) % 4) >= 2);
            e_sren = (cyc >= 40) && (cyc < 96) && (((cyc - 40) % 4) == 2);
            if (adc_cnv !== e_cnv) cnv_bad++;
            if (adc_sclk !== e_sclk) sclk_bad++;
            if (sr_enable !== e_sren) sren_bad++;
            if (sr_enable === 1'b1) sren_cnt++;
            if (overrun === 1'b1) ovr_cnt++;
            if (cyc == 96) v96 = sample_valid;
            if (cyc == 97) begin v97 = sample_valid; d97 = sample_data; end
            if (cyc == 98) v98 = sample_valid;
            adv_to(cyc + 1);
        end
        chk({tag, "_cnv_shape"},  cnv_bad, 0);
        chk({tag, "_sclk_shape"}, sclk_bad, 0);
        chk({tag, "_sren_pos"},   sren_bad, 0);
        chk({tag, "_sren_cnt"},   sren_cnt, DW);
        chk({tag, "_ovr_none"},   ovr_cnt, 0);
        chk({tag, "_vld96"},      v96, 0);
        chk({tag, "_vld97"},      v97, 1);
        chk({tag, "_data97"},     d97, w);
        chk({tag, "_vld98"},      v98, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not reach its summary (cyc=%0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int cnv_seen, ovr_cnt, ovr_bad, drop_bad, exp_drop;
        logic e_ovr;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ctl",  {adc_cnv, adc_sclk, sr_enable, sample_valid, overrun}, 0);
        chk("rst_data", sample_data, 0);
        chk("rst_drop", drop_count, 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_cnv", adc_cnv, 0);

        // single capture, then stop
        sample_ready = 1'b1;
        go("cap");
        start_en = 1'b0;
        chk_conv("cap", 14'h2A5C);
        adv_to(200);
        chk("cap_no_cnv200", adc_cnv, 0);
        adv_to(210);

        // backpressure: hold 0001, drop 3FFF
        sample_ready = 1'b0;
        adc_word = 14'h0001;
        go("bp");
        adv_to(97);
        chk("bp_vld97",  sample_valid, 1);
        chk("bp_data97", sample_data, 14'h0001);
        chk("bp_ovr97",  overrun, 0);
        adv_to(100);
        adc_word = 14'h3FFF;
        adv_to(199);
        chk("bp_cnv199", adc_cnv, 0);
        adv_to(200);
        chk("bp_cnv200", adc_cnv, 1);
        adv_to(296);
        chk("bp_ovr296", overrun, 0);
        adv_to(297);
        chk("bp_ovr297",  overrun, 1);
        chk("bp_data297", sample_data, 14'h0001);
        chk("bp_vld297",  sample_valid, 1);
        chk("bp_drop297", drop_count, 1);
        adv_to(298);
        chk("bp_ovr298",  overrun, 0);

        // ready coincides with LATCH: new word replaces the taken one
        adv_to(300);
        adc_word = 14'h1234;
        adv_to(495);
        chk("sim_data495", sample_data, 14'h0001);
        adv_to(496);
        sample_ready = 1'b1;
        adv_to(497);
        chk("sim_data497", sample_data, 14'h1234);
        chk("sim_vld497",  sample_valid, 1);
        chk("sim_ovr497",  overrun, 0);
        chk("sim_drop497", drop_count, 1);
        sample_ready = 1'b0;
        adv_to(498);
        chk("sim_vld498", sample_valid, 1);
        sample_ready = 1'b1;
        adv_to(499);
        chk("sim_vld499", sample_valid, 0);

        // stop mid-shift: word still delivered, then IDLE
        adv_to(500);
        adc_word = 14'h0ABC;
        adv_to(660);
        start_en = 1'b0;
        adv_to(697);
        chk("stop_vld697",  sample_valid, 1);
        chk("stop_data697", sample_data, 14'h0ABC);
        adv_to(698);
        chk("stop_vld698", sample_valid, 0);
        cnv_seen = 0;
        while (cyc < 820) begin
            if (adc_cnv !== 1'b0) cnv_seen++;
            adv_to(cyc + 1);
        end
        chk("stop_no_cnv", cnv_seen, 0);

        // saturation: 1 held word, 260 drops on top of the earlier one
        sample_ready = 1'b0;
        adc_word = 14'h1555;
        go("sat");
        exp_drop = 1;
        ovr_cnt  = 0;
        ovr_bad  = 0;
        drop_bad = 0;
        while (cyc <= 260 * 200 + 100) begin
            if (cyc == 100) adc_word = 14'h2222;
            e_ovr = ((cyc % 200) == 97) && (cyc >= 200);
            if (e_ovr && exp_drop < 255) exp_drop++;
            if (overrun !== e_ovr) ovr_bad++;
            if (overrun === 1'b1) ovr_cnt++;
            if ((cyc % 200) == 98 && drop_count !== 8'(exp_drop)) drop_bad++;
            adv_to(cyc + 1);
        end
        chk("sat_ovr_cnt",  ovr_cnt, 260);
        chk("sat_ovr_pos",  ovr_bad, 0);
        chk("sat_drop_trk", drop_bad, 0);
        chk("sat_drop",     drop_count, 255);
        chk("sat_data",     sample_data, 14'h1555);
        chk("sat_vld",      sample_valid, 1);

        // reset mid-SHIFT, then clean restart
        adv_to(261 * 200 + 60);
        resetn = 1'b0;
        #1;
        chk("mid_rst_ctl",  {adc_cnv, adc_sclk, sr_enable, sample_valid, overrun}, 0);
        chk("mid_rst_data", sample_data, 0);
        chk("mid_rst_drop", drop_count, 0);
        repeat (2) @(negedge clk);
        chk("mid_rst_hold", {adc_cnv, adc_sclk, sr_enable, sample_valid, overrun}, 0);
        resetn = 1'b1;
        #1;
        chk("rel_cnv_pre", adc_cnv, 0);
        @(negedge clk);
        cyc = 0;
        chk("rel_cnv0", adc_cnv, 1);
        sample_ready = 1'b1;
        start_en = 1'b0;
        chk_conv("rel", 14'h1A5B);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
